// File: rtl/cdc_pkg.sv
// Shared state type, default word width and helpers for the CDC handshake transmitter.
package cdc_pkg;

  localparam int CDC_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2,
    RECOVER     = 2'd3
  } cdc_tx_state_t;

  // True while a handshake phase is outstanding and the phase timer should run.
  function automatic logic is_wait_state(input cdc_tx_state_t s);
    return (s == WAIT_ACK_HI) || (s == WAIT_ACK_LO);
  endfunction

endpackage

// File: rtl/ack_sync2.sv
// Two-flop synchronizer bringing the destination acknowledge into the clk domain.
module ack_sync2
  import cdc_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack clock-domain-crossing handshake.
// Define CDC_TX_TIMEOUT_EN to add the per-phase timeout and the RECOVER state.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = CDC_DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  send_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ack_async,
  output logic                  ready,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  timeout_err
);

  cdc_tx_state_t state, state_next;
  logic          ack_s;
  logic          req_d;
  logic          done_d;
  logic          load;

  ack_sync2 u_ack_sync (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (ack_async),
    .sync_out (ack_s)
  );

`ifdef CDC_TX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] phase_cnt;
  logic             phase_expired;
  logic             tmo_d;

  assign phase_expired = (phase_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Phase timer restarts on every state change so each phase gets its own budget.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_cnt <= '0;
    end else if ((state_next != state) || !is_wait_state(state)) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_d;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // Blocking sends during the done cycle keeps a new request from starting
  // before the caller has seen the previous completion.
  assign ready = (state == IDLE) && !done;

  always_comb begin
    state_next = state;
    req_d      = req_out;
    done_d     = 1'b0;
    load       = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
    tmo_d      = 1'b0;
`endif
    case (state)
      IDLE: begin
        req_d = 1'b0;
        if (send_valid && !done) begin
          load       = 1'b1;
          req_d      = 1'b1;
          state_next = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: begin
`ifdef CDC_TX_TIMEOUT_EN
        if (phase_expired) begin
          req_d      = 1'b0;
          tmo_d      = 1'b1;
          state_next = RECOVER;
        end else
`endif
        if (ack_s) begin
          req_d      = 1'b0;
          state_next = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        req_d = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        if (phase_expired) begin
          tmo_d      = 1'b1;
          state_next = RECOVER;
        end else
`endif
        if (!ack_s) begin
          done_d     = 1'b1;
          state_next = IDLE;
        end
      end
      RECOVER: begin
        req_d = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        if (!ack_s) begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: begin
        req_d      = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      state   <= state_next;
      req_out <= req_d;
      done    <= done_d;
      if (load) begin
        data_out <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx; the timeout case runs only with CDC_TX_TIMEOUT_EN.
module tb_cdc_handshake_tx;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       send_valid;
  logic [7:0] data_in;
  logic       ack_async;
  logic       ready;
  logic       req_out;
  logic [7:0] data_out;
  logic       done;
  logic       timeout_err;

  int         errors = 0;
  int         checks = 0;
  int         done_count = 0;
  int         tmo_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_word = 8'h00;

  // Acknowledge source: 0 = manual level, 1 = zero-delay mirror of req_out, 2 = 3-cycle delayed mirror.
  int         ack_mode = 0;
  logic       ack_manual = 1'b0;
  logic [2:0] req_hist = 3'b000;

  assign ack_async = (ack_mode == 1) ? req_out :
                     (ack_mode == 2) ? req_hist[2] : ack_manual;

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .send_valid  (send_valid),
    .data_in     (data_in),
    .ack_async   (ack_async),
    .ready       (ready),
    .req_out     (req_out),
    .data_out    (data_out),
    .done        (done),
    .timeout_err (timeout_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Waits for ready, then holds the send for the accepting edge.
  task automatic applyStimulus(input logic [7:0] word, input bit hold);
    int guard;
    guard = 0;
    @(negedge clk);
    data_in    = word;
    send_valid = 1'b1;
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_in_time", 32'(guard < 200), 1);
    @(posedge clk);
    cur_word = word;
    exp_q.push_back(word);
    #1;
    if (!hold) send_valid = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (!done && cycles < 300);
    checkOutput("done_in_time", done, 1);
  endtask

  task automatic waitReqLow();
    int guard;
    guard = 0;
    while (req_out && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("req_low_in_time", req_out, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      req_hist = {req_hist[1:0], req_out};
    end
  end

  // Monitor: data_out must only ever hold the last accepted word; each done pops one expectation.
  initial begin
    logic       prev_done;
    logic [7:0] w;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      checkOutput("data_out_hold", data_out, cur_word);
      if (done) begin
        done_count++;
        checkOutput("done_single_pulse", prev_done, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1 with data %0h, expected no done", data_out);
        end else begin
          w = exp_q.pop_front();
          checkOutput("done_data", data_out, w);
        end
      end
      if (timeout_err) tmo_count++;
      prev_done = done;
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int d0;
    send_valid = 1'b0;
    data_in    = 8'h00;
    n_rst      = 1'b0;
    ack_mode   = 0;
    ack_manual = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", ready, 1);
    checkOutput("reset_req", req_out, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_timeout", timeout_err, 0);
    checkOutput("reset_data", data_out, 8'h00);
    n_rst = 1'b1;

    $display("[TB] basic transfer A5");
    ack_mode = 2;
    applyStimulus(8'hA5, 0);
    @(negedge clk);
    checkOutput("basic_req_high", req_out, 1);
    checkOutput("basic_data", data_out, 8'hA5);
    checkOutput("basic_busy", ready, 0);
    waitDone(n);
    send_valid = 1'b1;
    data_in    = 8'h77;
    @(posedge clk);
    #1 send_valid = 1'b0;
    @(negedge clk);
    checkOutput("done_cycle_send_ignored", req_out, 0);
    checkOutput("basic_ready_back", ready, 1);
    repeat (4) @(negedge clk);

    $display("[TB] minimum latency with zero-delay ack");
    ack_mode = 1;
    applyStimulus(8'h5A, 0);
    waitDone(n);
    checkOutput("min_latency", n, 6);
    repeat (4) @(negedge clk);

    $display("[TB] back-to-back 3C then C3");
    ack_mode = 2;
    d0 = done_count;
    applyStimulus(8'h3C, 1);
    applyStimulus(8'hC3, 0);
    checkOutput("b2b_second_after_done", done_count - d0, 1);
    waitDone(n);
    repeat (4) @(negedge clk);

    $display("[TB] busy send during WAIT_ACK_LO");
    applyStimulus(8'h96, 0);
    @(negedge clk);
    waitReqLow();
    send_valid = 1'b1;
    data_in    = 8'hFF;
    @(posedge clk);
    #1 send_valid = 1'b0;
    @(negedge clk);
    checkOutput("busy_ignored_data", data_out, 8'h96);
    checkOutput("busy_req_low", req_out, 0);
    waitDone(n);
    repeat (4) @(negedge clk);

    $display("[TB] spurious ack in IDLE");
    ack_mode   = 0;
    ack_manual = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("spurious_req", req_out, 0);
    checkOutput("spurious_ready", ready, 1);
    checkOutput("spurious_done", done, 0);
    ack_manual = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("spurious_after_req", req_out, 0);
    checkOutput("spurious_after_ready", ready, 1);

`ifdef CDC_TX_TIMEOUT_EN
    $display("[TB] timeout with ack held low");
    applyStimulus(8'hE7, 0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!timeout_err && n < 100);
    checkOutput("timeout_latency", n, 16);
    checkOutput("timeout_req_low", req_out, 0);
    checkOutput("timeout_no_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    checkOutput("timeout_pulse_once", timeout_err, 0);
    checkOutput("timeout_ready", ready, 1);
    checkOutput("timeout_count", tmo_count, 1);
    repeat (4) @(negedge clk);
`else
    $display("[TB] no timeout: request held while ack stays low");
    applyStimulus(8'h3E, 0);
    repeat (300) @(negedge clk);
    checkOutput("hold_req_high", req_out, 1);
    checkOutput("hold_no_timeout", tmo_count, 0);
    ack_manual = 1'b1;
    waitReqLow();
    ack_manual = 1'b0;
    waitDone(n);
    repeat (4) @(negedge clk);
`endif

    $display("[TB] reset during WAIT_ACK_HI");
    ack_manual = 1'b0;
    applyStimulus(8'h42, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_req", req_out, 1);
    #2;
    n_rst    = 1'b0;
    cur_word = 8'h00;
    exp_q.delete();
    #1;
    checkOutput("reset_mid_req", req_out, 0);
    checkOutput("reset_mid_ready", ready, 1);
    checkOutput("reset_mid_data", data_out, 8'h00);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("post_reset_ready", ready, 1);
    checkOutput("post_reset_req", req_out, 0);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
